// File: rtl/btb_pkg.sv
// Shared types for the BTB write-port scheduler.
// Entry layout, table geometry and scheduler states.
package btb_pkg;

    localparam int BTB_ENTRIES = 8;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_W   = 3;
    localparam int BTB_TGT_W   = 6;

    typedef struct packed {
        logic                 valid;
        logic [BTB_IDX_W-1:0] idx;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_TGT_W-1:0] tgt;
    } btb_wr_t;

    typedef enum logic {
        IDLE,
        SWEEP
    } btb_state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB writes.
// Flush wins over push and pop in the same cycle.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  btb_wr_t       din,
    input  logic          pop,
    input  logic          flush,
    output btb_wr_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    btb_wr_t       mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/btb_update_sched.sv
// BTB write-port scheduler: filters EX resolutions, queues
// the needed writes and issues one per cycle or sweeps the table.
module btb_update_sched
    import btb_pkg::*;
#(
    parameter int QDEPTH     = 4,
    parameter int ENTRIES    = BTB_ENTRIES,
    parameter int IDX_W      = $clog2(ENTRIES),
    parameter int TAG_W      = BTB_TAG_W,
    parameter int TGT_W      = BTB_TGT_W,
    parameter int STARVE_MAX = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      upd_valid,
    output logic                      upd_ready,
    input  logic [7:0]                upd_pc,
    input  logic [7:0]                upd_target,
    input  logic                      upd_taken,
    input  logic                      upd_hit,
    input  logic                      upd_tgt_match,
    input  logic                      memory_stall,
    input  logic [IDX_W-1:0]          fetch_idx,
    input  logic                      inval_req,
    output logic                      wr_en,
    output logic [IDX_W-1:0]          wr_idx,
    output logic                      wr_valid,
    output logic [TAG_W-1:0]          wr_tag,
    output logic [TGT_W-1:0]          wr_tgt,
    output logic                      inval_busy,
    output logic [$clog2(QDEPTH):0]   q_count
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    btb_state_t       state;
    btb_state_t       state_nx;
    logic [IDX_W-1:0] sweep_cnt;
    logic [IDX_W-1:0] sweep_nx;
    logic [SW-1:0]    starve;
    logic [SW-1:0]    starve_nx;

    btb_wr_t upd_ent;
    btb_wr_t head;
    logic    want_alloc;
    logic    want_inval;
    logic    push;
    logic    fifo_full;
    logic    fifo_empty;
    logic    conflict;
    logic    issue;

    // Only mispredicting or stale entries cost a BTB write.
    always_comb begin
        upd_ent    = '0;
        want_alloc = upd_taken && (!upd_hit || !upd_tgt_match);
        want_inval = !upd_taken && upd_hit;
        upd_ent.valid = want_alloc;
        upd_ent.idx   = upd_pc[IDX_W+1:2];
        upd_ent.tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        upd_ent.tgt   = want_alloc ? upd_target[TGT_W+1:2] : '0;
    end

    assign upd_ready = (state == IDLE) && !fifo_full;
    assign push      = upd_valid && upd_ready
                       && (want_alloc || want_inval);

    assign conflict = (head.idx == fetch_idx);
    assign issue    = (state == IDLE) && !fifo_empty
                      && !memory_stall
                      && (!conflict || starve == SW'(STARVE_MAX));

    btb_upd_fifo #(
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (upd_ent),
        .pop   (issue),
        .flush (inval_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    always_comb begin
        starve_nx = starve;
        if (inval_req || issue)
            starve_nx = '0;
        else if (state == IDLE && !fifo_empty
                 && !memory_stall && conflict)
            starve_nx = starve + 1'b1;
    end

    always_comb begin
        state_nx   = state;
        sweep_nx   = sweep_cnt;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_valid   = 1'b0;
        wr_tag     = '0;
        wr_tgt     = '0;
        inval_busy = 1'b0;
        unique case (state)
            IDLE: begin
                if (issue) begin
                    wr_en    = 1'b1;
                    wr_idx   = head.idx;
                    wr_valid = head.valid;
                    wr_tag   = head.tag;
                    wr_tgt   = head.tgt;
                end
            end
            SWEEP: begin
                inval_busy = 1'b1;
                wr_en      = 1'b1;
                wr_idx     = sweep_cnt;
                if (sweep_cnt == IDX_W'(ENTRIES - 1))
                    state_nx = IDLE;
                else
                    sweep_nx = sweep_cnt + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
        if (inval_req) begin
            state_nx = SWEEP;
            sweep_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            starve    <= '0;
        end else begin
            state     <= state_nx;
            sweep_cnt <= sweep_nx;
            starve    <= starve_nx;
        end
    end

endmodule

// File: doc/btb_update_sched.md
Name: btb_update_sched

Overview:
- Write-port scheduler for the 8-entry direct-mapped branch target buffer.
- Takes branch-resolution results from the EX stage and filters them down to the writes the BTB actually needs.
- Buffers those writes in a small FIFO and issues at most one write per cycle. Issue is deferred while the memory system stalls or fetch is reading the same BTB index; a starvation bound limits how long a write can be deferred.
- Sequences a full-table invalidate sweep on request, e.g. for fence.i or a context switch.

Parameters:
- QDEPTH, 4, update FIFO depth (power of two, ≥2)
- ENTRIES, 8, BTB entries; IDX_W = log2(ENTRIES)
- TAG_W, 3, BTB tag width
- TGT_W, 6, stored target width (word address bits)
- STARVE_MAX, 3, maximum consecutive cycles a pending head write may be deferred by fetch-index conflict

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- upd_valid  in  1  EX-stage resolved branch present
- upd_ready  out  1  scheduler can accept an update this cycle
- upd_pc  in  8  branch PC bits [7:0]; index = [IDX_W+1:2], tag = next TAG_W bits
- upd_target  in  8  resolved target bits [7:0]; stored value = [TGT_W+1:2]
- upd_taken  in  1  branch resolved taken
- upd_hit  in  1  BTB hit at fetch time for this branch
- upd_tgt_match  in  1  stored BTB target equalled resolved target
- memory_stall  in  1  pipeline frozen by the memory system
- fetch_idx  in  IDX_W  BTB index being read by fetch this cycle
- inval_req  in  1  single-cycle pulse: invalidate the whole BTB
- wr_en  out  1  BTB write strobe
- wr_idx  out  IDX_W  entry to write
- wr_valid  out  1  valid bit to write
- wr_tag  out  TAG_W  tag to write
- wr_tgt  out  TGT_W  target to write
- inval_busy  out  1  invalidate sweep in progress
- q_count  out  log2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: state IDLE, FIFO empty, starvation counter 0. All outputs 0 except upd_ready, which is 1.
- upd_ready = (state == IDLE) && (q_count < QDEPTH). A handshake occurs when upd_valid && upd_ready.
- Filtering on handshake:
  - taken && (!upd_hit || !upd_tgt_match) → enqueue an allocate entry {valid=1, idx, tag, tgt}.
  - !taken && upd_hit → enqueue an invalidate entry {valid=0, idx, tag, tgt=0}.
  - Any other case is accepted but not enqueued.
- FIFO ordering is strict; there is no coalescing. Updates are visible in q_count the cycle after the handshake.
- IDLE issue rule: when the FIFO is non-empty and !memory_stall, issue the head if head.idx != fetch_idx OR the starvation counter == STARVE_MAX.
  - wr_* are combinational from the head entry; the BTB latches them at the next posedge, and the head pops at that same edge.
  - The starvation counter increments on each cycle a non-empty, non-stalled head is deferred by conflict. It clears on issue, and it holds while memory_stall is high.
- Simultaneous enqueue and pop at full occupancy is not possible because upd_ready is low when full. At any other occupancy, a simultaneous enqueue and pop leaves q_count unchanged.
- Pointer wrap-around is modulo QDEPTH.
- inval_req (any state) flushes the FIFO, resets the sweep counter to 0, and enters SWEEP on the next edge.
- SWEEP:
  - inval_busy = 1, upd_ready = 0.
  - Each cycle: wr_en = 1, wr_idx = sweep counter, wr_valid = 0, wr_tag = 0, wr_tgt = 0. memory_stall and fetch_idx are ignored.
  - After index ENTRIES-1 is written, return to IDLE. A sweep takes exactly ENTRIES cycles.
  - inval_req during SWEEP restarts the counter at 0.
- Updates presented during SWEEP are not accepted; the producer holds them.
- Asynchronous reset mid-sweep or mid-drain returns immediately to the reset values. In-flight writes are discarded.

Decomposition:
- Shared package btb_pkg holds:
  - the constants BTB_ENTRIES, BTB_IDX_W, BTB_TAG_W, BTB_TGT_W
  - the btb_wr_t struct {valid, idx, tag, tgt}
  - the state enum {IDLE, SWEEP}
- One natural sub-module: btb_upd_fifo, a parameterized synchronous FIFO of btb_wr_t with push, pop, flush, full, empty and count.
- Filtering, the starvation counter and the FSM stay in the top level.

Test Plan:
- Reset, then a taken miss (pc=0x2C, target=0x84): one cycle later q_count=1. Next cycle wr_en=1, wr_idx=3, wr_tag=1, wr_tgt=0x21, wr_valid=1.
- Not-taken hit at pc=0x08 while fetch_idx=2: write deferred 3 cycles, then forced on the 4th (STARVE_MAX=3) with wr_valid=0, wr_idx=2.
- Four taken misses back-to-back with memory_stall=1: q_count=4 and upd_ready=0. Releasing the stall drains 4 writes on 4 consecutive cycles, in order.
- Taken hit with upd_tgt_match=1, and a not-taken miss: both accepted, q_count stays 0, no wr_en.
- inval_req with 2 queued entries: FIFO cleared; wr_en high for exactly 8 cycles with wr_idx 0..7 and wr_valid=0; inval_busy for those 8 cycles; upd_ready returns 1 afterwards.
- rst asserted at sweep cycle 4: outputs go to reset values immediately, and no further writes occur after reset is released.
